// File: rtl/drp_reconf_seq.sv
// DRP master: walks an {address, mask, data} table, doing one read-modify-write
// per entry through the DRP port, then waits for PLL lock and pulses DONE.
module drp_reconf_seq #(
  parameter int NUM_ENTRIES  = 23,
  parameter int IDX_W        = 5,
  parameter int DRP_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic             DCLK,
  input  logic             RST,
  input  logic             START,
  input  logic             LOCKED,
  input  logic             DRDY,
  input  logic [15:0]      DO,
  input  logic [6:0]       ENTRY_ADDR,
  input  logic [15:0]      ENTRY_MASK,
  input  logic [15:0]      ENTRY_DATA,
  output logic [IDX_W-1:0] IDX,
  output logic [6:0]       DADDR,
  output logic             DEN,
  output logic             DWE,
  output logic [15:0]      DI,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int T_MAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] DRP_LIM  = CNT_W'(DRP_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_LOCK_WAIT, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;   // 0: waiting for DRDY low, 1: waiting for DRDY high
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rd_q, rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       daddr_q, daddr_d;
  logic             den_q, den_d;
  logic             dwe_q, dwe_d;
  logic [15:0]      di_q, di_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lock_s1_q, lock_s2_q;
  logic             lock_flush;
  logic             go_finish, set_err;

  assign IDX   = idx_q;
  assign DADDR = daddr_q;
  assign DEN   = den_q;
  assign DWE   = dwe_q;
  assign DI    = di_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    rd_d       = rd_q;
    idx_d      = idx_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    di_d       = di_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    lock_flush = 1'b0;
    go_finish  = 1'b0;
    set_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (START) begin
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        daddr_d = ENTRY_ADDR;
        den_d   = 1'b1;
        phase_d = 1'b0;
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_WR_REQ: begin
        di_d    = (rd_q & ENTRY_MASK) | (ENTRY_DATA & ~ENTRY_MASK);
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        phase_d = 1'b0;
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (!phase_q) begin
          if (!DRDY) begin
            phase_d = 1'b1;
            cnt_d   = '0;
            if (state_q == S_RD_WAIT) rd_d = DO;
          end else if (cnt_q == DRP_LIM) begin
            go_finish = 1'b1;
            set_err   = 1'b1;
          end
        end else begin
          if (DRDY) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            if (state_q == S_RD_WAIT) begin
              state_d = S_WR_REQ;
            end else if (idx_q == LAST_IDX) begin
              state_d    = S_LOCK_WAIT;
              lock_flush = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_RD_REQ;
            end
          end else if (cnt_q == DRP_LIM) begin
            go_finish = 1'b1;
            set_err   = 1'b1;
          end
        end
      end
      S_LOCK_WAIT: begin
        if (lock_s2_q) begin
          go_finish = 1'b1;
        end else if (cnt_q == LOCK_LIM) begin
          go_finish = 1'b1;
          set_err   = 1'b1;
        end
      end
      S_FINISH: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // DONE is raised on the edge that enters FINISH, so a START seen during the
    // DONE cycle lands in FINISH and is ignored.
    if (go_finish) begin
      state_d = S_FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = '0;
      if (set_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      daddr_q <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      di_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      daddr_q <= daddr_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      di_q    <= di_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The synchronizer is flushed after the last write so only LOCKED samples
  // taken after the reconfiguration can end LOCK_WAIT.
  always_ff @(posedge DCLK) begin
    if (RST || lock_flush) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= LOCKED;
      lock_s2_q <= lock_s1_q;
    end
  end

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Bench for drp_reconf_seq: behavioural DRP slave, table-driven reference model
// of the merged register values, directed scenarios with randomized table data.
module tb_drp_reconf_seq;
  localparam int N = 23;
  localparam int T = 16;
  localparam int L = 1024;
  localparam int RUN_CYC = 1 + 8 * N + 2 + 1;

  logic        DCLK = 1'b0;
  logic        RST, START, LOCKED, DRDY;
  logic [15:0] DO;
  logic [6:0]  ENTRY_ADDR;
  logic [15:0] ENTRY_MASK, ENTRY_DATA;
  logic [4:0]  IDX;
  logic [6:0]  DADDR;
  logic        DEN, DWE, BUSY, DONE, ERR;
  logic [15:0] DI;

  logic [6:0]  tab_addr[32];
  logic [15:0] tab_mask[32];
  logic [15:0] tab_data[32];

  assign ENTRY_ADDR = tab_addr[IDX];
  assign ENTRY_MASK = tab_mask[IDX];
  assign ENTRY_DATA = tab_data[IDX];

  drp_reconf_seq #(.NUM_ENTRIES(N), .IDX_W(5), .DRP_TIMEOUT(T), .LOCK_TIMEOUT(L)) dut (
    .DCLK(DCLK), .RST(RST), .START(START), .LOCKED(LOCKED), .DRDY(DRDY), .DO(DO),
    .ENTRY_ADDR(ENTRY_ADDR), .ENTRY_MASK(ENTRY_MASK), .ENTRY_DATA(ENTRY_DATA),
    .IDX(IDX), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 DCLK = ~DCLK;

  // DRP slave: DRDY idles high, low for one cycle after DEN with DO valid.
  logic [15:0] sl_mem[128];
  logic [15:0] init_mem[128];
  logic        sl_init = 1'b0;
  logic        sl_mute = 1'b0;
  logic        drdy_r = 1'b1;
  logic [15:0] do_r = 16'h0;
  assign DRDY = drdy_r;
  assign DO   = do_r;

  always @(posedge DCLK) begin
    if (sl_init) begin
      for (int a = 0; a < 128; a++) sl_mem[a] <= init_mem[a];
      drdy_r <= 1'b1;
    end else if (DEN && !sl_mute) begin
      drdy_r <= 1'b0;
      do_r   <= sl_mem[DADDR];
      if (DWE) sl_mem[DADDR] <= DI;
    end else begin
      drdy_r <= 1'b1;
    end
  end

  // Bus monitor
  logic [15:0] act_rd_q[$];
  logic [15:0] act_wr_q[$];
  int den_cnt = 0, den_viol = 0, done_cnt = 0;
  bit den_prev = 1'b0, last_we = 1'b0;

  always @(negedge DCLK) begin
    if (DEN) begin
      den_cnt++;
      if (den_prev) den_viol++;
      last_we = DWE;
      if (DWE) act_wr_q.push_back(DI);
    end
    if (!DRDY && !last_we) act_rd_q.push_back(DO);
    if (DONE) done_cnt++;
    den_prev = DEN;
  end

  // Reference model and scoreboard
  logic [15:0] exp_mem[128];
  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_wr_q[$];
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_load(input bit rnd);
    for (int a = 0; a < 128; a++) begin
      init_mem[a] = rnd ? 16'($urandom) : 16'h0;
      exp_mem[a]  = init_mem[a];
    end
    sl_init = 1'b1;
    @(negedge DCLK);
    sl_init = 1'b0;
  endtask

  task automatic model_run();
    logic [15:0] rd, wr;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < N; i++) begin
      rd = exp_mem[tab_addr[i]];
      wr = (rd & tab_mask[i]) | (tab_data[i] & ~tab_mask[i]);
      exp_rd_q.push_back(rd);
      exp_wr_q.push_back(wr);
      exp_mem[tab_addr[i]] = wr;
    end
  endtask

  task automatic cmp_queues(input string tag, input int rb, input int wb);
    check({tag, "_rd_count"}, act_rd_q.size() - rb, exp_rd_q.size());
    check({tag, "_wr_count"}, act_wr_q.size() - wb, exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size(); i++) begin
      if (rb + i < act_rd_q.size()) check({tag, "_rd_data"}, act_rd_q[rb + i], exp_rd_q[i]);
      if (wb + i < act_wr_q.size()) check({tag, "_wr_data"}, act_wr_q[wb + i], exp_wr_q[i]);
    end
  endtask

  task automatic cmp_mem(input string tag);
    for (int i = 0; i < N; i++) check(tag, sl_mem[tab_addr[i]], exp_mem[tab_addr[i]]);
  endtask

  task automatic wait_done(input int n0, input int max_cyc, output int n);
    n = n0;
    while (!DONE && n < max_cyc) begin
      @(negedge DCLK);
      n++;
    end
    check("done_seen", DONE, 1'b1);
  endtask

  // Call at a negedge; n is the cycle (START cycle = 0) in which DONE is seen.
  task automatic run(input bit hold, input int max_cyc, output int n);
    START = 1'b1;
    @(negedge DCLK);
    if (!hold) START = 1'b0;
    wait_done(1, max_cyc, n);
  endtask

  task automatic rand_table();
    for (int i = 0; i < 32; i++) begin
      tab_addr[i] = 7'($urandom_range(0, 127));
      tab_mask[i] = 16'($urandom);
      tab_data[i] = 16'($urandom);
    end
  endtask

  initial begin
    int n, n2, rb, wb, db, k;
    RST = 1'b1; START = 1'b0; LOCKED = 1'b1;
    rand_table();
    repeat (3) @(negedge DCLK);
    check("rst_den", DEN, 0);
    check("rst_dwe", DWE, 0);
    check("rst_daddr", DADDR, 0);
    check("rst_di", DI, 0);
    check("rst_idx", IDX, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;
    @(negedge DCLK);

    // Basic read-modify-write on a zeroed slave
    tab_addr[0] = 7'h08; tab_mask[0] = 16'h0000; tab_data[0] = 16'h0041;
    tab_addr[1] = 7'h08; tab_mask[1] = 16'h00FF; tab_data[1] = 16'h1200;
    slave_load(1'b0);
    model_run();
    rb = act_rd_q.size(); wb = act_wr_q.size(); db = den_cnt;
    run(1'b0, 400, n);
    check("basic_latency", n, RUN_CYC);
    check("basic_err", ERR, 0);
    check("basic_busy_at_done", BUSY, 0);
    check("basic_wr0", act_wr_q[wb], 16'h0041);
    check("basic_rd1", act_rd_q[rb + 1], 16'h0041);
    check("basic_wr1", act_wr_q[wb + 1], 16'h1241);
    check("basic_den_pulses", den_cnt - db, 2 * N);
    cmp_queues("basic", rb, wb);
    @(negedge DCLK);
    check("basic_done_pulse", DONE, 0);

    // Handshake check over the full address table
    k = 0;
    for (int a = 8'h06; a <= 8'h16; a++) begin tab_addr[k] = 7'(a); k++; end
    for (int a = 8'h18; a <= 8'h1A; a++) begin tab_addr[k] = 7'(a); k++; end
    tab_addr[k] = 7'h28; tab_addr[k + 1] = 7'h4E; tab_addr[k + 2] = 7'h4F;
    slave_load(1'b1);
    model_run();
    rb = act_rd_q.size(); wb = act_wr_q.size(); db = den_cnt;
    run(1'b0, 400, n);
    check("hs_latency", n, RUN_CYC);
    check("hs_err", ERR, 0);
    check("hs_den_pulses", den_cnt - db, 46);
    check("hs_den_back_to_back", den_viol, 0);
    cmp_queues("hs", rb, wb);
    cmp_mem("hs_mem");
    @(negedge DCLK);

    // DRP timeout: slave never answers
    sl_mute = 1'b1;
    db = den_cnt;
    run(1'b0, 100, n);
    check("drp_to_latency", n, T + 3);
    check("drp_to_err", ERR, 1);
    check("drp_to_idx", IDX, 0);
    check("drp_to_den_pulses", den_cnt - db, 1);
    sl_mute = 1'b0;
    @(negedge DCLK);

    // Lock timeout: all writes complete, then LOCK_TIMEOUT cycles in LOCK_WAIT
    LOCKED = 1'b0;
    slave_load(1'b1);
    model_run();
    rb = act_rd_q.size(); wb = act_wr_q.size(); db = den_cnt;
    run(1'b0, 3000, n);
    check("lock_to_latency", n, 1 + 8 * N + L + 1);
    check("lock_to_err", ERR, 1);
    check("lock_to_den_pulses", den_cnt - db, 2 * N);
    cmp_queues("lock_to", rb, wb);
    @(negedge DCLK);
    check("lock_to_err_sticky", ERR, 1);
    LOCKED = 1'b1;
    model_run();
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
    check("restart_err_clear", ERR, 0);
    check("restart_busy", BUSY, 1);
    wait_done(1, 400, n);
    check("restart_latency", n, RUN_CYC);
    check("restart_err", ERR, 0);
    @(negedge DCLK);

    // Reset during WR_WAIT of entry 3
    rand_table();
    slave_load(1'b1);
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
    n = 0;
    while (!(DEN && DWE && IDX == 5'd3) && n < 100) begin
      @(negedge DCLK);
      n++;
    end
    check("rst_mid_reached", DEN && DWE && IDX == 5'd3, 1);
    db = done_cnt;
    RST = 1'b1;
    @(negedge DCLK);
    RST = 1'b0;
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_den", DEN, 0);
    check("rst_mid_idx", IDX, 0);
    check("rst_mid_done", DONE, 0);
    repeat (30) @(negedge DCLK);
    check("rst_mid_no_done", done_cnt - db, 0);
    slave_load(1'b1);
    model_run();
    rb = act_rd_q.size(); wb = act_wr_q.size();
    run(1'b0, 400, n);
    check("rst_clean_latency", n, RUN_CYC);
    check("rst_clean_err", ERR, 0);
    cmp_queues("rst_clean", rb, wb);
    @(negedge DCLK);

    // START held high: one run, then a new run from the cycle after DONE
    db = done_cnt;
    run(1'b1, 400, n);
    check("hold_latency", n, RUN_CYC);
    @(negedge DCLK);
    check("hold_idle_busy", BUSY, 0);
    check("hold_idle_done", DONE, 0);
    check("hold_one_done", done_cnt - db, 1);
    @(negedge DCLK);
    START = 1'b0;
    check("hold_second_busy", BUSY, 1);
    wait_done(1, 400, n2);
    check("hold_second_latency", n2, RUN_CYC);
    check("hold_second_err", ERR, 0);
    @(negedge DCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drp_reconf_seq.md
# drp_reconf_seq

DRP master that sequences a reconfiguration of the PLL/MMCM model through its dynamic reconfiguration port (`dyn_reconf`). On `START` it walks an external entry table of `{address, mask, data}` triples. For each entry it does a read-modify-write of one DRP register, then waits for `LOCKED`. It sits directly upstream of the DRP slave and drives `DADDR/DEN/DWE/DI`. It consumes `DO/DRDY` with the slave's handshake: `DRDY` idles high, drops for one cycle after `DEN` with `DO` valid in that cycle, then returns high.

## Interface
Parameters:
- `NUM_ENTRIES`, 23: number of table entries processed per run; legal range 1..2^`IDX_W`.
- `IDX_W`, 5: width of the table index.
- `DRP_TIMEOUT`, 16: maximum `DCLK` cycles to wait for each DRP handshake phase.
- `LOCK_TIMEOUT`, 1024: maximum `DCLK` cycles to wait for `LOCKED` after the last write.

Ports:
- `DCLK` in 1: the single clock; all state changes on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: request a run; sampled only in IDLE.
- `LOCKED` in 1: PLL lock indication; may be asynchronous, so it is double-registered internally.
- `DRDY` in 1: DRP ready from the slave.
- `DO` in 16: DRP read data from the slave.
- `ENTRY_ADDR` in 7: table address for `IDX`; combinational from `IDX`.
- `ENTRY_MASK` in 16: table mask; a 1 keeps that bit of the read value.
- `ENTRY_DATA` in 16: table data; used only where the mask bit is 0.
- `IDX` out `IDX_W`: current table index.
- `DADDR` out 7: DRP address.
- `DEN` out 1: DRP enable.
- `DWE` out 1: DRP write enable.
- `DI` out 16: DRP write data.
- `BUSY` out 1: high from the cycle after `START` is accepted until the cycle `DONE` pulses.
- `DONE` out 1: one-cycle pulse at the end of every run.
- `ERR` out 1: sticky error flag; cleared only on acceptance of the next `START`.

## Operation
- All outputs are registered.
- Reset values: `DEN`=0, `DWE`=0, `DADDR`=0, `DI`=0, `IDX`=0, `BUSY`=0, `DONE`=0, `ERR`=0. After reset the FSM is in IDLE.

State machine:
- IDLE:
  - on `START`=1: `IDX`←0, `ERR`←0, `BUSY`←1, go to RD_REQ.
  - `START` in any other state is ignored.
- RD_REQ:
  - drive `DADDR`←`ENTRY_ADDR`, `DEN`←1, `DWE`←0 for exactly one cycle.
  - go to RD_WAIT with phase=LOW.
- RD_WAIT, phase LOW:
  - on the first cycle with `DRDY`=0, latch `rd_q`←`DO` and switch to phase HIGH.
- RD_WAIT, phase HIGH:
  - on `DRDY`=1, go to WR_REQ.
- WR_REQ:
  - drive `DI`←(`rd_q` & `ENTRY_MASK`) | (`ENTRY_DATA` & ~`ENTRY_MASK`), `DEN`←1, `DWE`←1 for one cycle; `DADDR` is unchanged.
  - go to WR_WAIT.
- WR_WAIT:
  - same two-phase wait as RD_WAIT; `DO` is ignored.
  - on completion: if `IDX`=`NUM_ENTRIES`-1 go to LOCK_WAIT, else `IDX`←`IDX`+1 and go to RD_REQ.
- LOCK_WAIT:
  - wait for synchronized `LOCKED`=1, then go to FINISH.
- FINISH:
  - `DONE`←1 for one cycle, `BUSY`←0, go to IDLE.

Timeouts and errors:
- A timeout counter is cleared on every phase/state change. It counts cycles within each DRP wait phase and within LOCK_WAIT.
- DRP timeout: reaching `DRP_TIMEOUT` in either wait phase sets `ERR`←1, drops `DEN`/`DWE`, and goes to FINISH. Remaining entries are skipped.
- Lock timeout: reaching `LOCK_TIMEOUT` in LOCK_WAIT sets `ERR`←1 and goes to FINISH.
- `DONE` pulses on both successful and failed runs; `ERR` distinguishes them.

Boundary rules:
- `RST` mid-run: the next edge returns to IDLE with all reset values; any in-flight DRP transaction is abandoned, and `DEN` is low from that edge.
- `START` in the same cycle as `DONE`: ignored, because the FSM is in FINISH. The earliest new run starts on `START` in the cycle after `DONE`.
- `NUM_ENTRIES`=1: a single read-modify-write, then LOCK_WAIT.
- Counters saturate; `IDX` never exceeds `NUM_ENTRIES`-1.

## Timing
- `DEN` is high for exactly one cycle per transaction and never high in two consecutive cycles.
- Against the `dyn_reconf` slave, per transaction: edge k `DEN`↑; edge k+1 `DEN`↓ and the slave drops `DRDY`; edge k+2 `DO` is latched and the slave raises `DRDY`; edge k+3 the phase completes.
- Each read-modify-write takes 8 cycles, RD_REQ to the next RD_REQ.
- Run latency with `LOCKED` already high: 1 (IDLE→RD_REQ) + 8·`NUM_ENTRIES` + 2 (synchronizer) + 1 (FINISH) cycles from `START` to `DONE`.

## Test plan
- **Basic read-modify-write.** `NUM_ENTRIES`=2; entry0 = (0x08, mask 0x0000, data 0x0041); entry1 = (0x08, mask 0x00FF, data 0x1200); `LOCKED`=1; slave freshly reset. Required:
  - first write `DI`=0x0041; second read returns 0x0041; second write `DI`=0x1241.
  - `DONE` at cycle 20 after `START`; `ERR`=0.
- **Handshake check.** Full 23-entry table covering addresses 0x06–0x16, 0x18–0x1A, 0x28, 0x4E, 0x4F. Required:
  - read back via the slave; every register equals its expected merged value.
  - `DEN` never high on consecutive cycles; 46 `DEN` pulses total.
- **DRP timeout.** `DRDY` held at 1. Required: `ERR`=1 and `DONE` at `DRP_TIMEOUT`+3 cycles after `START`; `IDX`=0; only one `DEN` pulse.
- **Lock timeout.** `LOCKED`=0 throughout. Required: all writes complete, then `ERR`=1 with `DONE` `LOCK_TIMEOUT` cycles after LOCK_WAIT entry. A new `START` clears `ERR`.
- **Reset mid-run.** `RST` pulsed during WR_WAIT of entry 3. Required: next cycle `BUSY`=0, `DEN`=0, `IDX`=0; no `DONE`; a following `START` runs cleanly.
- **Ignored START.** `START` held high throughout a run. Required: exactly one run until `DONE`, then a second run begins the cycle after `DONE`.
